bcd2bin_counter: RTL and testbench

- Reverse of the decimal-count display block: the operator sets a two-digit BCD value on switch1 (tens in [7:4], units in [3:0]) and loads it with button1.
- The block counts the BCD value down to 00 while counting a binary register up, converting decimal to binary by counting.
- The binary result is shown on ledG and hex4/hex5. The remaining BCD count is shown on hex6/hex7.
- Top-level board block: keys, switches, LEDs and 7-segment displays.

---
 rtl/bcd2bin_counter_if.sv | 22 ++
 rtl/bcd2bin_counter.sv | 138 +++++++++++++
 tb/tb_bcd2bin_counter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/bcd2bin_counter_if.sv
// rtl/bcd2bin_counter_if.sv - board I/O bundle for the BCD-to-binary counting converter
interface bcd2bin_counter_if;
    logic       button1;
    logic [7:0] switch1;
    logic [7:0] ledG;
    logic [7:0] ledR1;
    logic [6:0] hex4;
    logic [6:0] hex5;
    logic [6:0] hex6;
    logic [6:0] hex7;
    logic       ledG8;

    modport master (
        output button1, switch1,
        input  ledG, ledR1, hex4, hex5, hex6, hex7, ledG8
    );

    modport slave (
        input  button1, switch1,
        output ledG, ledR1, hex4, hex5, hex6, hex7, ledG8
    );
endinterface

// File: rtl/bcd2bin_counter.sv
// rtl/bcd2bin_counter.sv - converts a two-digit BCD operand to binary by counting it down to 00
module bcd2bin_counter #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic              clk,
    input  logic              button0,
    bcd2bin_counter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

    state_t      state_q, state_d;
    logic        key_r_q, key_rr_q;
    logic [7:0]  ledg_q, ledg_d;
    logic [7:0]  ledr_q, ledr_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  units_q, units_d;
    logic [15:0] presc_q, presc_d;
    logic        err_q, err_d;

    logic push;
    logic step;
    logic rem_zero;
    logic operand_bad;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            4'hF: seg7 = 7'b0001110;
            default: seg7 = 7'b0111111;
        endcase
    endfunction

    // Falling edge of the synchronised key; the flops idle high so reset release is not a push.
    assign push        = key_rr_q & ~key_r_q;
    assign step        = (state_q == RUN) && (presc_q == PRESC_MAX);
    assign rem_zero    = (tens_q == 4'd0) && (units_q == 4'd0);
    assign operand_bad = (bus.switch1[7:4] > 4'd9) || (bus.switch1[3:0] > 4'd9);

    always_ff @(posedge clk or negedge button0) begin
        if (!button0) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (push) begin
            state_d = operand_bad ? ERR : RUN;
        end else if (step && rem_zero) begin
            state_d = DONE;
        end
    end

    always_ff @(posedge clk or negedge button0) begin
        if (!button0) begin
            key_r_q  <= 1'b1;
            key_rr_q <= 1'b1;
            ledg_q   <= 8'd0;
            ledr_q   <= 8'd0;
            tens_q   <= 4'd0;
            units_q  <= 4'd0;
            presc_q  <= 16'd0;
            err_q    <= 1'b0;
        end else begin
            key_r_q  <= bus.button1;
            key_rr_q <= key_r_q;
            ledg_q   <= ledg_d;
            ledr_q   <= ledr_d;
            tens_q   <= tens_d;
            units_q  <= units_d;
            presc_q  <= presc_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        ledg_d  = ledg_q;
        ledr_d  = ledr_q;
        tens_d  = tens_q;
        units_d = units_q;
        presc_d = presc_q;
        err_d   = err_q;
        if (push) begin
            ledr_d  = bus.switch1;
            presc_d = 16'd0;
            ledg_d  = 8'd0;
            err_d   = operand_bad;
            if (operand_bad) begin
                tens_d  = 4'd0;
                units_d = 4'd0;
            end else begin
                tens_d  = bus.switch1[7:4];
                units_d = bus.switch1[3:0];
            end
        end else if (state_q == RUN) begin
            if (step) begin
                presc_d = 16'd0;
                if (!rem_zero) begin
                    ledg_d = ledg_q + 8'd1;
                    if (units_q == 4'd0) begin
                        units_d = 4'd9;
                        tens_d  = tens_q - 4'd1;
                    end else begin
                        units_d = units_q - 4'd1;
                    end
                end
            end else begin
                presc_d = presc_q + 16'd1;
            end
        end
    end

    assign bus.ledG  = ledg_q;
    assign bus.ledR1 = ledr_q;
    assign bus.ledG8 = err_q;
    assign bus.hex4  = seg7(ledg_q[3:0]);
    assign bus.hex5  = seg7(ledg_q[7:4]);
    assign bus.hex6  = seg7(units_q);
    assign bus.hex7  = seg7(tens_q);
endmodule

// File: tb/tb_bcd2bin_counter.sv
// tb/tb_bcd2bin_counter.sv - randomized model-checked bench for bcd2bin_counter at TICK_DIV 1 and 4
module tb_bcd2bin_counter;
    logic       clk = 1'b0;
    logic       button0 = 1'b1;
    logic       button1 = 1'b1;
    logic [7:0] switch1 = 8'h00;
    bit         checking = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd2bin_counter_if bus1 ();
    bcd2bin_counter_if bus4 ();

    assign bus1.button1 = button1;
    assign bus1.switch1 = switch1;
    assign bus4.button1 = button1;
    assign bus4.switch1 = switch1;

    bcd2bin_counter #(.TICK_DIV(1)) dut1 (.clk(clk), .button0(button0), .bus(bus1.slave));
    bcd2bin_counter #(.TICK_DIV(4)) dut4 (.clk(clk), .button0(button0), .bus(bus4.slave));

    logic [6:0] SEG [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Model: which operand was loaded and how many clock edges have passed since.
    bit         m_loaded = 1'b0;
    logic [7:0] m_op = 8'h00;
    int         m_el = 0;
    bit         k1 = 1'b1;
    bit         k2 = 1'b1;

    always @(posedge clk) begin
        if (!button0) begin
            m_loaded = 1'b0;
            m_el = 0;
            k1 = 1'b1;
            k2 = 1'b1;
        end else begin
            if (k2 && !k1) begin
                m_loaded = 1'b1;
                m_op = switch1;
                m_el = 0;
            end else begin
                m_el++;
            end
            k2 = k1;
            k1 = button1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string nm, input int td, input logic [7:0] g, input logic [7:0] r,
                             input logic [6:0] h4, input logic [6:0] h5, input logic [6:0] h6,
                             input logic [6:0] h7, input logic e);
        int eg, er, erem, ee, n, k;
        eg = 0; er = 0; erem = 0; ee = 0;
        if (button0 && m_loaded) begin
            er = m_op;
            if (m_op[7:4] > 9 || m_op[3:0] > 9) begin
                ee = 1;
            end else begin
                n = 10 * m_op[7:4] + m_op[3:0];
                k = m_el / td;
                eg = (k < n) ? k : n;
                erem = n - eg;
            end
        end
        chk({nm, ".ledG"},  32'(g),  32'(eg));
        chk({nm, ".ledR1"}, 32'(r),  32'(er));
        chk({nm, ".ledG8"}, 32'(e),  32'(ee));
        chk({nm, ".hex4"},  32'(h4), 32'(SEG[eg % 16]));
        chk({nm, ".hex5"},  32'(h5), 32'(SEG[eg / 16]));
        chk({nm, ".hex6"},  32'(h6), 32'(SEG[erem % 10]));
        chk({nm, ".hex7"},  32'(h7), 32'(SEG[erem / 10]));
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check_dut("td1", 1, bus1.ledG, bus1.ledR1, bus1.hex4, bus1.hex5, bus1.hex6, bus1.hex7, bus1.ledG8);
            check_dut("td4", 4, bus4.ledG, bus4.ledR1, bus4.hex4, bus4.hex5, bus4.hex6, bus4.hex7, bus4.ledG8);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Returns just after the load edge when hold is 2.
    task automatic press(input logic [7:0] op, input int hold);
        switch1 = op;
        button1 = 1'b0;
        cyc(hold);
        button1 = 1'b1;
    endtask

    initial begin
        logic [7:0] op;
        #1 button0 = 1'b0;
        #1 checking = 1'b1;
        cyc(3);
        chk("rst.ledG", 32'(bus1.ledG), 32'h0);
        chk("rst.ledR1", 32'(bus1.ledR1), 32'h0);
        chk("rst.hex4", 32'(bus1.hex4), 32'b1000000);
        chk("rst.hex7", 32'(bus4.hex7), 32'b1000000);
        chk("rst.ledG8", 32'(bus1.ledG8), 32'h0);
        button0 = 1'b1;
        cyc(2);

        press(8'h99, 2);
        cyc(99);
        chk("t1.ledG99", 32'(bus1.ledG), 32'h63);
        cyc(6);
        chk("t1.ledG", 32'(bus1.ledG), 32'h63);
        chk("t1.hex5", 32'(bus1.hex5), 32'b0000010);
        chk("t1.hex4", 32'(bus1.hex4), 32'b0110000);
        chk("t1.hex7", 32'(bus1.hex7), 32'b1000000);
        chk("t1.hex6", 32'(bus1.hex6), 32'b1000000);
        chk("t1.ledG8", 32'(bus1.ledG8), 32'h0);

        press(8'h00, 2);
        cyc(1);
        chk("t2.ledG", 32'(bus1.ledG), 32'h0);
        chk("t2.ledR1", 32'(bus1.ledR1), 32'h0);

        press(8'h1A, 2);
        cyc(3);
        chk("t3a.ledG8", 32'(bus1.ledG8), 32'h1);
        chk("t3a.ledR1", 32'(bus1.ledR1), 32'h1A);
        chk("t3a.ledG", 32'(bus1.ledG), 32'h0);
        press(8'hA1, 2);
        cyc(3);
        chk("t3b.ledG8", 32'(bus4.ledG8), 32'h1);
        chk("t3b.ledR1", 32'(bus4.ledR1), 32'hA1);
        press(8'h10, 2);
        cyc(1);
        chk("t3c.ledG8", 32'(bus1.ledG8), 32'h0);
        cyc(15);
        chk("t3c.ledG", 32'(bus1.ledG), 32'h0A);

        press(8'h50, 2);
        cyc(1);
        chk("t4.hex6", 32'(bus1.hex6), 32'b0010000);
        chk("t4.hex7", 32'(bus1.hex7), 32'b0011001);
        cyc(19);
        chk("t4.ledG20", 32'(bus1.ledG), 32'h14);
        press(8'h12, 2);
        cyc(20);
        chk("t4.ledG", 32'(bus1.ledG), 32'h0C);

        press(8'h25, 2);
        cyc(7);
        #1 button0 = 1'b0;
        #1;
        chk("t5.ledG", 32'(bus1.ledG), 32'h0);
        chk("t5.ledR1", 32'(bus1.ledR1), 32'h0);
        chk("t5.hex4", 32'(bus1.hex4), 32'b1000000);
        chk("t5.hex6", 32'(bus1.hex6), 32'b1000000);
        cyc(2);
        button0 = 1'b1;
        cyc(10);
        chk("t5.idle", 32'(bus1.ledG), 32'h0);
        switch1 = 8'h05;
        button1 = 1'b0;
        cyc(50);
        button1 = 1'b1;
        cyc(10);
        chk("t5.hold", 32'(bus1.ledG), 32'h05);
        chk("t5.holdr", 32'(bus1.ledR1), 32'h05);

        press(8'h03, 2);
        cyc(3);
        chk("t6.c3", 32'(bus4.ledG), 32'h0);
        cyc(1);
        chk("t6.c4", 32'(bus4.ledG), 32'h1);
        cyc(4);
        chk("t6.c8", 32'(bus4.ledG), 32'h2);
        cyc(4);
        chk("t6.c12", 32'(bus4.ledG), 32'h3);
        cyc(4);
        chk("t6.c16", 32'(bus4.ledG), 32'h3);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) < 2) begin
                op = 8'($urandom);
            end else begin
                op = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end
            press(op, $urandom_range(2, 6));
            switch1 = 8'($urandom);
            cyc($urandom_range(1, 450));
            if ($urandom_range(0, 7) == 0) begin
                #1 button0 = 1'b0;
                cyc(2);
                button0 = 1'b1;
                cyc($urandom_range(1, 5));
            end
        end

        cyc(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
